// File: rtl/store_align_buffer.sv
// store_align_buffer: aligns RISC-V SB/SH/SW stores to word lanes and queues byte-strobed word writes
// Optional feature macro STORE_MISALIGN_SPLIT_EN: split a misaligned SH/SW into two word writes.
// Ports:
//    clk, reset        clock, asynchronous active-high reset
//    st_valid/st_ready store handshake; st_addr byte address, st_data rs2 value, st_funct3 size
//    mem_valid/mem_ready head-entry handshake; mem_waddr word-aligned byte address,
//                      mem_wdata lane-aligned data, mem_wr byte strobes
//    sb_count, sb_empty occupancy; st_fault one-cycle pulse for a dropped store
module store_align_buffer #(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W = 32,
   parameter int SB_DEPTH = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic st_valid,
   output logic st_ready,
   input  logic [DM_ADDRESS-1:0] st_addr,
   input  logic [DATA_W-1:0] st_data,
   input  logic [2:0] st_funct3,
   output logic mem_valid,
   input  logic mem_ready,
   output logic [31:0] mem_waddr,
   output logic [31:0] mem_wdata,
   output logic [3:0] mem_wr,
   output logic [$clog2(SB_DEPTH+1)-1:0] sb_count,
   output logic sb_empty,
   output logic st_fault
);
   localparam int AW = $clog2(SB_DEPTH);
   localparam int CW = $clog2(SB_DEPTH+1);
   localparam int WW = DM_ADDRESS-2;
   typedef enum logic {IDLE, SPLIT_HI} state_t;
   state_t state_q, state_d;
   logic [WW-1:0] widx_q [SB_DEPTH];
   logic [31:0] data_q [SB_DEPTH];
   logic [3:0] strb_q [SB_DEPTH];
   logic [AW-1:0] rd_q, wr_q;
   logic [CW-1:0] count_q, count_d;
   logic fault_q, fault_d;
   logic full, accept, push, pop;
   logic [WW-1:0] push_widx, word;
   logic [31:0] push_data, al_data;
   logic [3:0] push_strb, al_strb;
   logic [1:0] off;
   logic is_sb, is_sh, is_sw, aligned;
   assign off = st_addr[1:0];
   assign word = st_addr[DM_ADDRESS-1:2];
   assign is_sb = st_funct3 == 3'b000;
   assign is_sh = st_funct3 == 3'b001;
   assign is_sw = st_funct3 == 3'b010;
   assign aligned = is_sb || (is_sh && !off[0]) || (is_sw && off == 2'd0);
   assign al_strb = is_sb ? 4'b0001 << off : is_sh ? 4'b0011 << off : 4'b1111;
   assign al_data = is_sb ? {4{st_data[7:0]}} : is_sh ? {2{st_data[15:0]}} : st_data[31:0];
   assign full = count_q == CW'(SB_DEPTH);
   assign mem_valid = count_q != '0;
   assign pop = mem_valid && mem_ready;
   assign count_d = count_q + CW'(push) - CW'(pop);
   assign mem_wr = mem_valid ? strb_q[rd_q] : 4'd0;
   assign mem_wdata = mem_valid ? data_q[rd_q] : 32'd0;
   assign mem_waddr = mem_valid ? 32'({widx_q[rd_q], 2'b00}) : 32'd0;
   assign sb_count = count_q;
   assign sb_empty = count_q == '0;
   assign st_fault = fault_q;
`ifdef STORE_MISALIGN_SPLIT_EN
   logic [63:0] split_data;
   logic [7:0] split_strb;
   logic [WW-1:0] hi_widx_q;
   logic [31:0] hi_data_q;
   logic [3:0] hi_strb_q;
   assign split_data = {32'd0, st_data[31:0]} << {off, 3'b000};
   assign split_strb = {4'd0, is_sh ? 4'b0011 : 4'b1111} << off;
   // high half is only ever consumed from SPLIT_HI, so it needs no reset
   always_ff @(posedge clk)
      if (accept && !aligned) begin
         hi_widx_q <= word + WW'(1);
         hi_data_q <= split_data[63:32];
         hi_strb_q <= split_strb[7:4];
      end
`endif
   always_comb begin
      state_d = state_q;
      fault_d = 1'b0;
      push = 1'b0;
      push_widx = word;
      push_data = al_data;
      push_strb = al_strb;
      st_ready = state_q == IDLE && !full;
      accept = st_valid && st_ready;
`ifdef STORE_MISALIGN_SPLIT_EN
      if (state_q == SPLIT_HI) begin
         push = !full;
         push_widx = hi_widx_q;
         push_data = hi_data_q;
         push_strb = hi_strb_q;
         state_d = full ? SPLIT_HI : IDLE;
      end else if (accept && !aligned && (is_sh || is_sw)) begin
         push = 1'b1;
         push_data = split_data[31:0];
         push_strb = split_strb[3:0];
         // an SH at offset 1 still fits one word and needs no second write
         state_d = split_strb[7:4] != 4'd0 ? SPLIT_HI : IDLE;
      end else
`endif
      if (accept) begin
         push = aligned;
         fault_d = !aligned;
      end
   end
   always_ff @(posedge clk)
      if (push) begin
         widx_q[wr_q] <= push_widx;
         data_q[wr_q] <= push_data;
         strb_q[wr_q] <= push_strb;
      end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q <= IDLE;
         rd_q <= '0;
         wr_q <= '0;
         count_q <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rd_q <= rd_q + AW'(pop);
         wr_q <= wr_q + AW'(push);
         count_q <= count_d;
         fault_q <= fault_d;
      end
endmodule

// File: tb/tb_store_align_buffer.sv
// tb_store_align_buffer: directed and randomized checks of store_align_buffer against a byte-level store model
module tb_store_align_buffer;
   logic clk = 1'b0, reset = 1'b0;
   logic st_valid = 1'b0, st_ready, mem_valid, mem_ready = 1'b0, sb_empty, st_fault;
   logic [8:0] st_addr = '0;
   logic [31:0] st_data = '0, mem_waddr, mem_wdata;
   logic [2:0] st_funct3 = '0, sb_count;
   logic [3:0] mem_wr;
   int n_cmp = 0, n_bad = 0;
   typedef struct packed {logic [31:0] a; logic [31:0] d; logic [3:0] s;} wr_t;
   wr_t exp_q[$];

   always #5 clk = ~clk;

   store_align_buffer #(.DM_ADDRESS(9), .DATA_W(32), .SB_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
      .st_data(st_data), .st_funct3(st_funct3), .mem_valid(mem_valid), .mem_ready(mem_ready),
      .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .sb_count(sb_count),
      .sb_empty(sb_empty), .st_fault(st_fault)
   );

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [8:0] a, input logic [31:0] d, input logic [2:0] f);
      st_valid = v;
      st_addr = a;
      st_data = d;
      st_funct3 = f;
   endtask

   // places each byte of the store at its byte address and groups the bytes by word
   function automatic void model_store(input logic [8:0] a, input logic [31:0] d, input logic [2:0] f3,
                                       output bit fault, output int nw);
      int sz, off;
      wr_t w0, w1;
`ifdef STORE_MISALIGN_SPLIT_EN
      logic [63:0] bytes;
      logic [7:0] en;
`endif
      fault = 1'b0;
      nw = 0;
      off = int'(a[1:0]);
      if (f3 > 3'd2) begin
         fault = 1'b1;
         return;
      end
      sz = 1 << f3;
      w0 = '0;
      w1 = '0;
      w0.a = {23'd0, a[8:2], 2'b00};
      w1.a = {23'd0, a[8:2] + 7'd1, 2'b00};
      if (off % sz == 0) begin
         w0.s = 4'((1 << sz) - 1) << off;
         w0.d = sz == 1 ? {4{d[7:0]}} : sz == 2 ? {2{d[15:0]}} : d;
         exp_q.push_back(w0);
         nw = 1;
         return;
      end
`ifdef STORE_MISALIGN_SPLIT_EN
      bytes = '0;
      en = '0;
      for (int k = 0; k < 4; k++) begin
         bytes[8*(off+k) +: 8] = d[8*k +: 8];
         if (k < sz) en[off+k] = 1'b1;
      end
      w0.d = bytes[31:0];
      w0.s = en[3:0];
      w1.d = bytes[63:32];
      w1.s = en[7:4];
      exp_q.push_back(w0);
      nw = 1;
      if (w1.s != 4'd0) begin
         exp_q.push_back(w1);
         nw = 2;
      end
`else
      fault = 1'b1;
`endif
   endfunction

   task automatic test_reset();
      mem_ready = 1'b0;
      drive(0, 0, 0, 0);
      #2 reset = 1'b1;
      #1;
      n_cmp++;
      if ({sb_empty, mem_valid, st_fault, sb_count} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin
         n_bad++;
         $display("FAIL reset_status: got empty=%b valid=%b fault=%b count=%0d, want 1 0 0 0", sb_empty, mem_valid, st_fault, sb_count);
      end
      n_cmp++;
      if ({mem_waddr, mem_wdata, mem_wr} !== 68'd0) begin
         n_bad++;
         $display("FAIL reset_port: got a=%h d=%h wr=%b, want zeros", mem_waddr, mem_wdata, mem_wr);
      end
      tick();
      reset = 1'b0;
      tick();
      n_cmp++;
      if (st_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_ready: got %b want 1", st_ready);
      end
   endtask

   task automatic test_sb();
      wr_t e [2];
      e[0] = {32'h004, 32'hDDDDDDDD, 4'b0010};
      e[1] = {32'h004, 32'h11111111, 4'b1000};
      mem_ready = 1'b0;
      drive(1, 9'h005, 32'hAABBCCDD, 3'b000);
      #1;
      n_cmp++;
      if ({st_ready, mem_valid} !== 2'b10) begin
         n_bad++;
         $display("FAIL sb_accept: got ready=%b valid=%b, want 1 0", st_ready, mem_valid);
      end
      tick();
      drive(1, 9'h007, 32'h00000011, 3'b000);
      #1;
      n_cmp++;
      if ({mem_valid, sb_count} !== {1'b1, 3'd1}) begin
         n_bad++;
         $display("FAIL sb_latency: got valid=%b count=%0d, want 1 1", mem_valid, sb_count);
      end
      tick();
      drive(0, 0, 0, 0);
      for (int i = 0; i < 2; i++) begin
         mem_ready = 1'b1;
         #1;
         n_cmp++;
         if ({mem_valid, mem_waddr, mem_wdata, mem_wr} !== {1'b1, e[i]}) begin
            n_bad++;
            $display("FAIL sb_write%0d: got v=%b a=%h d=%h wr=%b, want a=%h d=%h wr=%b", i, mem_valid, mem_waddr, mem_wdata, mem_wr, e[i].a, e[i].d, e[i].s);
         end
         tick();
      end
      mem_ready = 1'b0;
      #1;
      n_cmp++;
      if (sb_empty !== 1'b1) begin
         n_bad++;
         $display("FAIL sb_empty: got %b want 1", sb_empty);
      end
   endtask

   task automatic test_sh_sw();
      wr_t e [2];
      e[0] = {32'h008, 32'h12341234, 4'b1100};
      e[1] = {32'h010, 32'hCAFEF00D, 4'b1111};
      tick();
      mem_ready = 1'b0;
      drive(1, 9'h00A, 32'h00001234, 3'b001);
      tick();
      drive(1, 9'h010, 32'hCAFEF00D, 3'b010);
      tick();
      drive(0, 0, 0, 0);
      for (int i = 0; i < 2; i++) begin
         mem_ready = 1'b1;
         #1;
         n_cmp++;
         if ({mem_valid, mem_waddr, mem_wdata, mem_wr} !== {1'b1, e[i]}) begin
            n_bad++;
            $display("FAIL shsw_write%0d: got v=%b a=%h d=%h wr=%b, want a=%h d=%h wr=%b", i, mem_valid, mem_waddr, mem_wdata, mem_wr, e[i].a, e[i].d, e[i].s);
         end
         tick();
      end
      mem_ready = 1'b0;
   endtask

   task automatic test_back_pressure();
      logic [31:0] d [5];
      logic [31:0] a [5];
      mem_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         d[i] = $urandom;
         a[i] = 32'(i * 4 + (i == 4 ? 48 : 0));
      end
      for (int i = 0; i < 4; i++) begin
         drive(1, a[i][8:0], d[i], 3'b010);
         tick();
      end
      drive(1, a[4][8:0], d[4], 3'b010);
      #1;
      n_cmp++;
      if ({sb_count, st_ready} !== {3'd4, 1'b0}) begin
         n_bad++;
         $display("FAIL bp_full: got count=%0d ready=%b, want 4 0", sb_count, st_ready);
      end
      tick();
      #1;
      n_cmp++;
      if (sb_count !== 3'd4) begin
         n_bad++;
         $display("FAIL bp_stall: got count=%0d want 4", sb_count);
      end
      mem_ready = 1'b1;
      #1;
      n_cmp++;
      if ({st_ready, mem_valid} !== 2'b01) begin
         n_bad++;
         $display("FAIL bp_nobypass: got ready=%b valid=%b, want 0 1", st_ready, mem_valid);
      end
      tick();
      mem_ready = 1'b0;
      #1;
      n_cmp++;
      if ({sb_count, st_ready} !== {3'd3, 1'b1}) begin
         n_bad++;
         $display("FAIL bp_release: got count=%0d ready=%b, want 3 1", sb_count, st_ready);
      end
      tick();
      drive(0, 0, 0, 0);
      for (int i = 1; i < 5; i++) begin
         mem_ready = 1'b1;
         #1;
         n_cmp++;
         if ({mem_valid, mem_waddr, mem_wdata, mem_wr} !== {1'b1, a[i], d[i], 4'hF}) begin
            n_bad++;
            $display("FAIL bp_write%0d: got v=%b a=%h d=%h wr=%b, want a=%h d=%h wr=1111", i, mem_valid, mem_waddr, mem_wdata, mem_wr, a[i], d[i]);
         end
         tick();
      end
      mem_ready = 1'b0;
   endtask

   task automatic test_illegal();
      mem_ready = 1'b0;
      drive(1, 9'h000, $urandom, 3'b011);
      #1;
      n_cmp++;
      if ({st_ready, st_fault} !== 2'b10) begin
         n_bad++;
         $display("FAIL ill_accept: got ready=%b fault=%b, want 1 0", st_ready, st_fault);
      end
      tick();
      drive(0, 0, 0, 0);
      #1;
      n_cmp++;
      if ({st_fault, sb_count, mem_valid} !== {1'b1, 3'd0, 1'b0}) begin
         n_bad++;
         $display("FAIL ill_pulse: got fault=%b count=%0d valid=%b, want 1 0 0", st_fault, sb_count, mem_valid);
      end
      tick();
      n_cmp++;
      if ({st_fault, sb_count} !== {1'b0, 3'd0}) begin
         n_bad++;
         $display("FAIL ill_end: got fault=%b count=%0d, want 0 0", st_fault, sb_count);
      end
   endtask

   task automatic test_misalign();
`ifdef STORE_MISALIGN_SPLIT_EN
      wr_t e [2];
      e[0] = {32'h1FC, 32'h33221100, 4'b1110};
      e[1] = {32'h000, 32'h00000044, 4'b0001};
`endif
      mem_ready = 1'b0;
      drive(1, 9'h1FD, 32'h44332211, 3'b010);
      #1;
      n_cmp++;
      if (st_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL mis_accept: got ready=%b want 1", st_ready);
      end
      tick();
      drive(0, 0, 0, 0);
`ifdef STORE_MISALIGN_SPLIT_EN
      #1;
      n_cmp++;
      if ({st_ready, st_fault, sb_count} !== {1'b0, 1'b0, 3'd1}) begin
         n_bad++;
         $display("FAIL mis_split: got ready=%b fault=%b count=%0d, want 0 0 1", st_ready, st_fault, sb_count);
      end
      tick();
      n_cmp++;
      if ({st_ready, sb_count} !== {1'b1, 3'd2}) begin
         n_bad++;
         $display("FAIL mis_hi: got ready=%b count=%0d, want 1 2", st_ready, sb_count);
      end
      for (int i = 0; i < 2; i++) begin
         mem_ready = 1'b1;
         #1;
         n_cmp++;
         if ({mem_valid, mem_waddr, mem_wdata, mem_wr} !== {1'b1, e[i]}) begin
            n_bad++;
            $display("FAIL mis_write%0d: got v=%b a=%h d=%h wr=%b, want a=%h d=%h wr=%b", i, mem_valid, mem_waddr, mem_wdata, mem_wr, e[i].a, e[i].d, e[i].s);
         end
         tick();
      end
      mem_ready = 1'b0;
`else
      #1;
      n_cmp++;
      if ({st_fault, sb_count, mem_valid} !== {1'b1, 3'd0, 1'b0}) begin
         n_bad++;
         $display("FAIL mis_drop: got fault=%b count=%0d valid=%b, want 1 0 0", st_fault, sb_count, mem_valid);
      end
      tick();
`endif
   endtask

   task automatic test_reset_split();
      mem_ready = 1'b0;
      drive(1, 9'h020, 32'h0BADBEEF, 3'b010);
      tick();
      drive(1, 9'h1FD, 32'h44332211, 3'b010);
      tick();
      drive(0, 0, 0, 0);
`ifdef STORE_MISALIGN_SPLIT_EN
      #1;
      n_cmp++;
      if ({sb_count, st_ready} !== {3'd2, 1'b0}) begin
         n_bad++;
         $display("FAIL rs_pre: got count=%0d ready=%b, want 2 0", sb_count, st_ready);
      end
`endif
      #1 reset = 1'b1;
      #1;
      n_cmp++;
      if ({sb_empty, mem_valid, sb_count} !== {1'b1, 1'b0, 3'd0}) begin
         n_bad++;
         $display("FAIL rs_flush: got empty=%b valid=%b count=%0d, want 1 0 0", sb_empty, mem_valid, sb_count);
      end
      #1 reset = 1'b0;
      tick();
      n_cmp++;
      if (st_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL rs_ready: got %b want 1", st_ready);
      end
      mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_cmp++;
         if (mem_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rs_nohi%0d: got valid=%b a=%h want valid 0", i, mem_valid, mem_waddr);
         end
         tick();
      end
      mem_ready = 1'b0;
   endtask

   task automatic test_random();
      bit hip = 1'b0, exp_fault = 1'b0, f;
      int nw, cnt;
      wr_t e;
      for (int c = 0; c < 430; c++) begin
         if (c < 400)
            drive(1'($urandom_range(0, 1)), 9'($urandom), $urandom,
                  ($urandom_range(0, 5) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2)));
         else
            drive(0, 0, 0, 0);
         mem_ready = c >= 400 || $urandom_range(0, 2) != 0;
         #1;
         cnt = exp_q.size() - int'(hip);
         n_cmp++;
         if ({sb_count, st_ready, mem_valid, st_fault} !== {3'(cnt), !hip && cnt < 4, cnt != 0, exp_fault}) begin
            n_bad++;
            $display("FAIL rnd_status c=%0d: got count=%0d ready=%b valid=%b fault=%b, want %0d %b %b %b", c, sb_count, st_ready, mem_valid, st_fault, cnt, !hip && cnt < 4, cnt != 0, exp_fault);
         end
         if (mem_valid && mem_ready && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({mem_waddr, mem_wdata, mem_wr} !== e) begin
               n_bad++;
               $display("FAIL rnd_write c=%0d: got a=%h d=%h wr=%b, want a=%h d=%h wr=%b", c, mem_waddr, mem_wdata, mem_wr, e.a, e.d, e.s);
            end
         end else if (!mem_valid) begin
            n_cmp++;
            if ({mem_waddr, mem_wdata, mem_wr} !== 68'd0) begin
               n_bad++;
               $display("FAIL rnd_idle c=%0d: got a=%h d=%h wr=%b, want zeros", c, mem_waddr, mem_wdata, mem_wr);
            end
         end
         if (hip && cnt < 4) hip = 1'b0;
         exp_fault = 1'b0;
         if (st_valid && st_ready) begin
            model_store(st_addr, st_data, st_funct3, f, nw);
            exp_fault = f;
            hip = nw == 2;
         end
         tick();
      end
      n_cmp++;
      if (exp_q.size() != 0 || hip) begin
         n_bad++;
         $display("FAIL rnd_drain: got %0d writes still expected, want 0", exp_q.size());
      end
      mem_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_sb();
      test_sh_sw();
      test_back_pressure();
      test_illegal();
      test_misalign();
      test_reset_split();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule

// File: doc/store_align_buffer.md
Name: store_align_buffer

Overview:
- Write-side companion of the data memory's load path. Takes RISC-V stores (SB/SH/SW) from the execute stage and aligns the data to the word lane.
- Generates the 4-bit byte-write strobes and buffers aligned entries in a small FIFO, draining one word write per accepted memory cycle.
- Sits between the core's store issue and the word-addressed data memory write port (Wr/waddress/Datain).

Parameters:
- DM_ADDRESS, 9, byte-address width of the data memory.
- DATA_W, 32, data width; fixed at 32 (4 byte lanes).
- SB_DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- st_valid  in  1  store request present.
- st_ready  out  1  store request accepted this cycle when high together with st_valid.
- st_addr  in  DM_ADDRESS  byte address of the store.
- st_data  in  DATA_W  register rs2 value (unshifted).
- st_funct3  in  3  instruction bits 14:12.
- mem_valid  out  1  head entry presented to memory.
- mem_ready  in  1  memory takes the head entry this cycle.
- mem_waddr  out  32  word-aligned byte address, zero-extended, bits 1:0 = 0.
- mem_wdata  out  32  lane-aligned write data.
- mem_wr  out  4  byte strobes; bit i enables byte lane i.
- sb_count  out  $clog2(SB_DEPTH+1)  occupied entries.
- sb_empty  out  1  sb_count == 0.
- st_fault  out  1  one-cycle pulse for a dropped store (illegal or misaligned).

Behaviour:
- Reset values: FIFO empty, sb_count=0, sb_empty=1, mem_valid=0, st_fault=0, FSM=IDLE. While mem_valid=0, mem_wr=0, mem_waddr=0 and mem_wdata=0.
- Entry format: {word index a[DM_ADDRESS-1:2], wdata[31:0], strb[3:0]}.
- Alignment (off = addr[1:0]):
  - SB (000): strb = 0001<<off; wdata = {4{data[7:0]}}.
  - SH (001), off in {0,2}: strb = 0011<<off; wdata = {2{data[15:0]}}.
  - SW (010), off = 0: strb = 1111; wdata = data.
- funct3 outside {000, 001, 010} is illegal:
  - The request is accepted (st_ready follows the normal rule), nothing is enqueued, and st_fault pulses.
- Push happens when st_valid && st_ready. Timing:
  - The entry is registered into the FIFO at that edge.
  - Earliest mem_valid is the next cycle (1-cycle latency when the FIFO was empty).
- Pop happens when mem_valid && mem_ready.
  - mem_* outputs are driven combinationally from the head entry.
  - mem_wr is masked to 0 when the FIFO is empty.
- st_ready = (state==IDLE) && !full. A push is refused when full, even if a pop occurs in the same cycle (no full-bypass).
- A push and a pop in the same cycle with the FIFO not full: sb_count is unchanged, and the pointers advance modulo SB_DEPTH.
- When empty, a push does not forward combinationally to the memory port in the same cycle.
- st_fault is registered: it is high exactly in the cycle after the faulting store is accepted.
- FSM states: IDLE, SPLIT_HI (the second state is used only with the optional feature enabled).
- Reset asserted in any state:
  - Flushes all entries.
  - Discards a pending split half.
  - Returns to IDLE asynchronously.

Optional Feature:
- Macro: STORE_MISALIGN_SPLIT_EN.
- Defined: a misaligned SH (off=3) or SW (off≠0) is split into two word writes.
  - Form a 64-bit shifted value {hi,lo} = data << (8*off).
  - Form 8-bit strobes m = base<<off, with base = 0011 for SH and 1111 for SW.
  - In IDLE the low entry (word W, m[3:0], lo) is pushed, and the FSM moves to SPLIT_HI holding the high entry (word W+1 mod 2^(DM_ADDRESS-2), m[7:4], hi). st_ready is 0 in SPLIT_HI.
  - In SPLIT_HI, when !full, the high entry is pushed and the FSM returns to IDLE.
  - No st_fault is raised for misaligned stores.
- Undefined: misaligned SH/SW is accepted, dropped, and raises st_fault; SPLIT_HI is unreachable.

Test Plan:
- SB sequence: addr 0x005, data 0xAABBCCDD, then addr 0x007, data 0x11 -> two memory writes:
  - waddr 0x004, wr 0010, wdata 0xDDDDDDDD.
  - waddr 0x004, wr 1000, wdata 0x11111111.
  - First mem_valid appears 1 cycle after the first accept.
- SH addr 0x00A, data 0x1234 -> waddr 0x008, wr 1100, wdata 0x12341234. SW addr 0x010, data 0xCAFEF00D -> wr 1111.
- Back-pressure: hold mem_ready=0 and push 4 SW stores -> sb_count=4, st_ready=0, and a 5th store stalls. Raise mem_ready for one cycle -> sb_count=3 and st_ready=1 the next cycle.
- Illegal funct3=011 at addr 0x000 -> st_fault high for exactly 1 cycle after accept, nothing enqueued, sb_count unchanged.
- Misaligned SW addr 0x1FD, data 0x44332211:
  - With the macro: writes (waddr 0x1FC, wr 1110, wdata 0x33221100), then (waddr 0x000, wr 0001, wdata 0x00000044); st_ready is low for 1 cycle between them.
  - Without the macro: st_fault pulse and no write.
- Reset asserted mid-SPLIT_HI with 2 entries queued -> immediately sb_empty=1, mem_valid=0, and st_ready=1 after release; the high half is never written.
